shift_issue_stage: RTL and testbench
====================================

Name: shift_issue_stage

Overview:
Registered issue stage directly upstream of barrel_shift_mips. Decodes MIPS shift instructions (SLL/SRL/SRA/ROTR and the variable forms SLLV/SRLV/SRAV/ROTRV) from the instruction word and operand values, and drives data_in/shift_count/op to the shifter. Uses a valid/ready handshake on both sides with a 2-entry skid buffer, so in_ready is a registered signal. Non-shift instructions are consumed, dropped and counted.

Parameters:
DATA_WIDTH, 32, operand and shifter data width
ADDR_WIDTH, 5, shift-count width; also register-specifier width
CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage can accept; registered
instr  in  32  MIPS instruction word
rs_val  in  DATA_WIDTH  value of register rs
rt_val  in  DATA_WIDTH  value of register rt
out_valid  out  1  shifter operands valid
out_ready  in  1  downstream consumes this cycle
sh_data  out  DATA_WIDTH  to shifter data_in (always rt_val)
sh_count  out  ADDR_WIDTH  to shifter shift_count
sh_op  out  2  to shifter op: 0 lo_l, 1 lo_r, 2 al_r, 3 ci_r
sh_rd  out  ADDR_WIDTH  destination register, instr[15:11]
issue_cnt  out  CNT_WIDTH  saturating count of forwarded shifts
drop_cnt  out  CNT_WIDTH  saturating count of dropped non-shift instructions

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1, sh_data/sh_count/sh_op/sh_rd=0, both counters=0, skid empty. Reset asserted mid-transfer discards all held entries.
- Decode applies only when opcode instr[31:26]=0. sa=instr[10:6], R=instr[21] for immediate forms, V=instr[6] for variable forms.
- funct 000000 SLL: op 0, count sa.
- funct 000010: R=0 gives SRL (op 1), R=1 gives ROTR (op 3); count sa.
- funct 000011 SRA: op 2, count sa.
- funct 000100 SLLV: op 0, count rs_val[4:0].
- funct 000110: V=0 gives SRLV (op 1), V=1 gives ROTRV (op 3); count rs_val[4:0].
- funct 000111 SRAV: op 2, count rs_val[4:0].
- Any other opcode or funct is a non-shift instruction. It is accepted (handshake completes), not forwarded, and drop_cnt increments by 1.
- Accept condition is in_valid && in_ready. Latency is 1 cycle: an accepted shift appears on the outputs the next cycle when the output register is empty or is being consumed.
- Output register holds its value while out_valid && !out_ready. Outputs are stable under backpressure.
- Skid buffer: when the output register is stalled and a shift is accepted, the entry goes to the skid register. in_ready deasserts the cycle after the skid fills.
- When the output is consumed, the skid entry moves to the output register and in_ready reasserts on the next cycle.
- Order is strictly FIFO. Nothing is lost or duplicated.
- Simultaneous accept and consume with the skid empty: the new entry loads the output register directly, giving a sustained throughput of 1 per cycle.
- A dropped instruction never occupies a buffer slot and is accepted even while the output is stalled, provided in_ready=1.
- issue_cnt increments when a shift is accepted. Both counters saturate at all-ones.
- Output fields are don't-care while out_valid=0, but they must hold their last value (no X).

Decomposition:
- Package shift_pkg holds: op encodings (OP_LO_L=0, OP_LO_R=1, OP_AL_R=2, OP_CI_R=3), funct constants (F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV), OPC_SPECIAL, and a packed entry struct {data, count, op, rd}.
- One combinational sub-module, shift_decode, maps {instr, rs_val} to {is_shift, count, op}.
- The top module contains the skid buffer, handshake and counters.

Test Plan:
- instr=0x00021900, rt_val=0x12345678, out_ready=1 -> next cycle: out_valid=1, sh_data=0x12345678, sh_count=4, sh_op=0, sh_rd=3; issue_cnt=1.
- instr=0x00221842 (ROTR rd3, rt2, sa1) -> sh_count=1, sh_op=3. instr=0x00021842 (SRL) -> sh_op=1.
- instr=0x00822807 (SRAV rd5, rt2, rs4), rs_val=0xFFFFFFE2, rt_val=0xF2345678 -> sh_count=2 (rs_val[4:0]), sh_op=2, sh_rd=5.
- instr=0x00430820 (ADD) -> in_ready stays 1, out_valid stays 0, drop_cnt=1, issue_cnt unchanged.
- out_ready=0; push shifts A, B, C back-to-back -> A and B accepted, in_ready=0 from the cycle after B, C held upstream. Raise out_ready -> outputs A, B, C in order with no gaps once flowing, then in_ready=1.
- With 2 entries held, pulse rst_n=0 for a half cycle (asynchronously) -> out_valid=0 and in_ready=1 immediately, counters=0. After release, a new SLL issues normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings and the buffered entry format for the shift issue stage.
package shift_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_ADDR_W = 5;

    localparam logic [1:0] OP_LO_L = 2'd0;
    localparam logic [1:0] OP_LO_R = 2'd1;
    localparam logic [1:0] OP_AL_R = 2'd2;
    localparam logic [1:0] OP_CI_R = 2'd3;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] F_SLL       = 6'b000000;
    localparam logic [5:0] F_SRL       = 6'b000010;
    localparam logic [5:0] F_SRA       = 6'b000011;
    localparam logic [5:0] F_SLLV      = 6'b000100;
    localparam logic [5:0] F_SRLV      = 6'b000110;
    localparam logic [5:0] F_SRAV      = 6'b000111;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] data;
        logic [PKG_ADDR_W-1:0] count;
        logic [1:0]            op;
        logic [PKG_ADDR_W-1:0] rd;
    } entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of MIPS shift instructions into shifter op and count.
module shift_decode
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = PKG_DATA_W,
    parameter int ADDR_WIDTH = PKG_ADDR_W
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_val,
    output logic                  is_shift,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [1:0]            op
);

    logic [ADDR_WIDTH-1:0] sa;
    logic [ADDR_WIDTH-1:0] rs_cnt;
    logic                  unused_bits;

    assign sa          = ADDR_WIDTH'(instr[10:6]);
    assign rs_cnt      = rs_val[ADDR_WIDTH-1:0];
    assign unused_bits = ^{instr[20:11], rs_val[DATA_WIDTH-1:ADDR_WIDTH]};

    // The rotate forms reuse the logical-right functs, told apart by instr[21] / instr[6].
    always_comb begin
        is_shift = 1'b0;
        count    = sa;
        op       = OP_LO_L;
        if (instr[31:26] == OPC_SPECIAL) begin
            is_shift = 1'b1;
            case (instr[5:0])
                F_SLL:   op = OP_LO_L;
                F_SRL:   op = instr[21] ? OP_CI_R : OP_LO_R;
                F_SRA:   op = OP_AL_R;
                F_SLLV:  begin op = OP_LO_L; count = rs_cnt; end
                F_SRLV:  begin op = instr[6] ? OP_CI_R : OP_LO_R; count = rs_cnt; end
                F_SRAV:  begin op = OP_AL_R; count = rs_cnt; end
                default: is_shift = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Registered shift issue stage: decode, 2-entry skid buffer toward the shifter,
// and saturating issue/drop statistics.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = PKG_DATA_W,
    parameter int ADDR_WIDTH = PKG_ADDR_W,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sh_data,
    output logic [ADDR_WIDTH-1:0] sh_count,
    output logic [1:0]            sh_op,
    output logic [ADDR_WIDTH-1:0] sh_rd,
    output logic [CNT_WIDTH-1:0]  issue_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    logic                  dec_shift;
    logic [ADDR_WIDTH-1:0] dec_count;
    logic [1:0]            dec_op;

    shift_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dec (
        .instr    (instr),
        .rs_val   (rs_val),
        .is_shift (dec_shift),
        .count    (dec_count),
        .op       (dec_op)
    );

    entry_t out_q, skid_q, out_d, skid_d, new_e;
    logic   out_vld, skid_vld, out_vld_d, skid_vld_d;
    logic   in_rdy_q;
    logic   acc, acc_shift, acc_drop, out_free;

    assign acc       = in_valid && in_rdy_q;
    assign acc_shift = acc && dec_shift;
    assign acc_drop  = acc && !dec_shift;
    assign out_free  = !out_vld || out_ready;

    always_comb begin
        new_e.data  = rt_val;
        new_e.count = dec_count;
        new_e.op    = dec_op;
        new_e.rd    = ADDR_WIDTH'(instr[15:11]);
    end

    // in_ready is low exactly while the skid holds an entry, so an accept
    // never coincides with a skid-to-output transfer.
    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld;
        skid_vld_d = skid_vld;
        if (out_free) begin
            if (skid_vld) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (acc_shift) begin
                out_d     = new_e;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (acc_shift) begin
            skid_d     = new_e;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_vld   <= 1'b0;
            skid_vld  <= 1'b0;
            in_rdy_q  <= 1'b1;
            issue_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_vld  <= out_vld_d;
            skid_vld <= skid_vld_d;
            in_rdy_q <= !skid_vld_d;
            if (acc_shift && (issue_cnt != '1)) issue_cnt <= issue_cnt + 1'b1;
            if (acc_drop && (drop_cnt != '1))   drop_cnt  <= drop_cnt + 1'b1;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld;
    assign sh_data   = out_q.data;
    assign sh_count  = out_q.count;
    assign sh_op     = out_q.op;
    assign sh_rd     = out_q.rd;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed and randomized checks of shift_issue_stage against a queue-based reference model.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sh_data;
    logic [4:0]  sh_count;
    logic [1:0]  sh_op;
    logic [4:0]  sh_rd;
    logic [15:0] issue_cnt;
    logic [15:0] drop_cnt;

    shift_issue_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_data   (sh_data),
        .sh_count  (sh_count),
        .sh_op     (sh_op),
        .sh_rd     (sh_rd),
        .issue_cnt (issue_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  count;
        logic [1:0]  op;
        logic [4:0]  rd;
    } m_ent_t;

    m_ent_t pend[$];
    int     m_issue = 0;
    int     m_drop  = 0;
    int     checks  = 0;
    int     errors  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference decode written mnemonic by mnemonic from the instruction set rules.
    function automatic void ref_dec(input logic [31:0] w, input logic [31:0] rsv,
                                    output bit sh, output logic [4:0] cnt, output logic [1:0] op);
        sh  = 1'b1;
        cnt = w[10:6];
        op  = 2'd0;
        if (w[31:26] != 6'd0) sh = 1'b0;
        else case (w[5:0])
            6'h00: op = 2'd0;
            6'h02: op = w[21] ? 2'd3 : 2'd1;
            6'h03: op = 2'd2;
            6'h04: begin op = 2'd0; cnt = rsv[4:0]; end
            6'h06: begin op = w[6] ? 2'd3 : 2'd1; cnt = rsv[4:0]; end
            6'h07: begin op = 2'd2; cnt = rsv[4:0]; end
            default: sh = 1'b0;
        endcase
    endfunction

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(pend.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(pend.size() < 2));
        chk("issue_cnt", 64'(issue_cnt), 64'(m_issue));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (pend.size() > 0) begin
            chk("sh_data", 64'(sh_data), 64'(pend[0].data));
            chk("sh_count", 64'(sh_count), 64'(pend[0].count));
            chk("sh_op", 64'(sh_op), 64'(pend[0].op));
            chk("sh_rd", 64'(sh_rd), 64'(pend[0].rd));
        end else begin
            chk("no_x", 64'(^{sh_data, sh_count, sh_op, sh_rd} === 1'bx), 64'd0);
        end
    endtask

    // One clock: the model consumes and accepts using the pre-edge inputs.
    task automatic cycle();
        bit          acc, cons, sh;
        logic [4:0]  cnt;
        logic [1:0]  op;
        m_ent_t      e;
        acc  = in_valid && (pend.size() < 2);
        cons = out_ready && (pend.size() > 0);
        ref_dec(instr, rs_val, sh, cnt, op);
        e.data  = rt_val;
        e.count = cnt;
        e.op    = op;
        e.rd    = instr[15:11];
        @(posedge clk);
        if (cons) void'(pend.pop_front());
        if (acc && sh) begin
            pend.push_back(e);
            if (m_issue < 65535) m_issue++;
        end
        if (acc && !sh && m_drop < 65535) m_drop++;
        #1;
        compare_all();
    endtask

    task automatic rand_instr();
        logic [5:0] sf[8];
        logic [5:0] of[6];
        int         k;
        logic [31:0] w;
        sf = '{6'h00, 6'h02, 6'h02, 6'h03, 6'h04, 6'h06, 6'h06, 6'h07};
        of = '{6'h20, 6'h21, 6'h01, 6'h05, 6'h08, 6'h2a};
        w  = $urandom;
        k  = $urandom_range(0, 9);
        if (k < 8) begin
            w[31:26] = 6'd0;
            w[5:0]   = sf[k];
        end else if (k == 8) begin
            w[31:26] = 6'd0;
            w[5:0]   = of[$urandom_range(0, 5)];
        end else begin
            w[31:26] = 6'($urandom_range(1, 63));
            w[5:0]   = sf[$urandom_range(0, 7)];
        end
        instr  = w;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", 64'({sh_data, sh_count, sh_op, sh_rd} == '0), 64'd1);
        chk("rst_cnts", 64'({issue_cnt, drop_cnt}), 64'd0);
        rst_n = 1'b1;

        // SLL rd3, rt2, sa4
        instr = 32'h00021900; rt_val = 32'h12345678; rs_val = 32'h0; out_ready = 1'b1;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("sll_valid", 64'(out_valid), 64'd1);
        chk("sll_data", 64'(sh_data), 64'h12345678);
        chk("sll_count", 64'(sh_count), 64'd4);
        chk("sll_op", 64'(sh_op), 64'd0);
        chk("sll_rd", 64'(sh_rd), 64'd3);
        chk("sll_issue", 64'(issue_cnt), 64'd1);
        cycle();

        // ROTR and SRL share a funct
        instr = 32'h00221842; in_valid = 1'b1;
        cycle();
        chk("rotr_count", 64'(sh_count), 64'd1);
        chk("rotr_op", 64'(sh_op), 64'd3);
        instr = 32'h00021842;
        cycle();
        in_valid = 1'b0;
        chk("srl_op", 64'(sh_op), 64'd1);
        cycle();

        // SRAV takes its count from rs_val
        instr = 32'h00822807; rs_val = 32'hFFFFFFE2; rt_val = 32'hF2345678; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("srav_count", 64'(sh_count), 64'd2);
        chk("srav_op", 64'(sh_op), 64'd2);
        chk("srav_rd", 64'(sh_rd), 64'd5);
        chk("srav_data", 64'(sh_data), 64'hF2345678);
        cycle();

        // ADD is dropped
        instr = 32'h00430820; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("add_ready", 64'(in_ready), 64'd1);
        chk("add_valid", 64'(out_valid), 64'd0);
        chk("add_drop", 64'(drop_cnt), 64'd1);
        chk("add_issue", 64'(issue_cnt), 64'd4);

        // Backpressure: A, B accepted, C held until the skid drains
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00021900; rt_val = 32'hAAAA0001; cycle();
        instr = 32'h00021842; rt_val = 32'hBBBB0002; cycle();
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        instr = 32'h00021903; rt_val = 32'hCCCC0003; cycle();
        chk("bp_hold_a", 64'(sh_data), 64'hAAAA0001);
        out_ready = 1'b1;
        for (int i = 0; i < 6 && in_valid; i++) begin
            if (pend.size() < 2) begin cycle(); in_valid = 1'b0; end
            else cycle();
        end
        chk("bp_c_accepted", 64'(in_valid), 64'd0);
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_ready_back", 64'(in_ready), 64'd1);

        // Asynchronous reset with two entries held
        out_ready = 1'b0; in_valid = 1'b1;
        rand_instr(); instr[31:26] = 6'd0; instr[5:0] = 6'h03; cycle();
        rand_instr(); instr[31:26] = 6'd0; instr[5:0] = 6'h07; cycle();
        in_valid = 1'b0;
        chk("pre_rst_held", 64'(pend.size()), 64'd2);
        rst_n = 1'b0;
        #2;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_cnts", 64'({issue_cnt, drop_cnt}), 64'd0);
        pend.delete(); m_issue = 0; m_drop = 0;
        #3 rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1;
        instr = 32'h00021900; rt_val = 32'h0F0F0F0F;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(sh_data), 64'h0F0F0F0F);
        chk("post_rst_issue", 64'(issue_cnt), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_instr();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("drained", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
